// File: rtl/bmf_pkg.sv
// Shared types and defaults for the BMF stream decompressor.
package bmf_pkg;

  typedef enum logic [1:0] {S_CFG, S_RUN, S_DRAIN} state_e;
  typedef enum logic {SR_OR, SR_XOR} semiring_e;

  localparam int unsigned DefaultK = 3;
  localparam int unsigned DefaultM = 4;

  // Row-index width that stays at least one bit wide for rank-1 matrices.
  function automatic int unsigned row_w(int unsigned k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage

// File: rtl/bmf_row_combine.sv
// Combinational expansion of a K-bit basis code over a K x M factor matrix (OR or XOR semiring).
module bmf_row_combine #(
  parameter int unsigned K = 3,
  parameter int unsigned M = 4
) (
  input  logic [K-1:0]        code_i,
  input  logic [K-1:0][M-1:0] rows_i,
  input  logic                xor_mode_i,
  output logic [M-1:0]        data_o
);

  always_comb begin
    data_o = '0;
    for (int unsigned k = 0; k < K; k++) begin
      if (code_i[k]) begin
        data_o = xor_mode_i ? (data_o ^ rows_i[k]) : (data_o | rows_i[k]);
      end
    end
  end

endmodule

// File: rtl/bmf_stream_decompressor.sv
// Streaming BMF decompressor: runtime-loaded factor matrix, config/run/drain FSM, registered output.
module bmf_stream_decompressor
  import bmf_pkg::*;
#(
  parameter int unsigned K    = DefaultK,
  parameter int unsigned M    = DefaultM,
  parameter int unsigned RowW = row_w(K)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_we_i,
  input  logic [RowW-1:0] cfg_row_i,
  input  logic [M-1:0]    cfg_data_i,
  input  logic            cfg_xor_i,
  input  logic            cfg_commit_i,
  input  logic            cfg_req_i,
  output logic            cfg_busy_o,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [K-1:0]    in_code_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [M-1:0]    out_data_o
);

  state_e              state_q;
  semiring_e           xor_mode_q;
  logic [K-1:0][M-1:0] rows_q;
  logic                cfg_busy_q;
  logic                out_valid_q;
  logic [M-1:0]        out_data_q;
  logic [M-1:0]        combined;
  logic                accept;

  bmf_row_combine #(
    .K (K),
    .M (M)
  ) u_row_combine (
    .code_i     (in_code_i),
    .rows_i     (rows_q),
    .xor_mode_i (xor_mode_q == SR_XOR),
    .data_o     (combined)
  );

  // Skid-free pipeline stage: a consumed output frees the slot in the same cycle.
  assign in_ready_o  = (state_q == S_RUN) && (!out_valid_q || out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign cfg_busy_o  = cfg_busy_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_CFG;
      xor_mode_q  <= SR_OR;
      rows_q      <= '0;
      cfg_busy_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        S_CFG: begin
          if (cfg_we_i) begin
            for (int unsigned k = 0; k < K; k++) begin
              if (cfg_row_i == RowW'(k)) rows_q[k] <= cfg_data_i;
            end
          end
          if (cfg_commit_i) begin
            xor_mode_q <= semiring_e'(cfg_xor_i);
            state_q    <= S_RUN;
            cfg_busy_q <= 1'b0;
          end
        end
        S_RUN: begin
          if (cfg_req_i) begin
            state_q    <= S_DRAIN;
            cfg_busy_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (!out_valid_q) state_q <= S_CFG;
        end
        default: begin
          state_q    <= S_CFG;
          cfg_busy_q <= 1'b1;
        end
      endcase

      if (accept) begin
        out_data_q  <= combined;
        out_valid_q <= 1'b1;
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bmf_stream_decompressor.sv
// Directed and randomized bench for bmf_stream_decompressor against a behavioural matrix model.
module tb_bmf_stream_decompressor;

  localparam int unsigned K    = 3;
  localparam int unsigned M    = 4;
  localparam int unsigned RowW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cfg_we;
  logic [RowW-1:0] cfg_row;
  logic [M-1:0]    cfg_data;
  logic            cfg_xor;
  logic            cfg_commit;
  logic            cfg_req;
  logic            cfg_busy;
  logic            in_valid;
  logic            in_ready;
  logic [K-1:0]    in_code;
  logic            out_valid;
  logic            out_ready;
  logic [M-1:0]    out_data;

  always #5 clk = ~clk;

  bmf_stream_decompressor #(
    .K    (K),
    .M    (M),
    .RowW (RowW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_we_i     (cfg_we),
    .cfg_row_i    (cfg_row),
    .cfg_data_i   (cfg_data),
    .cfg_xor_i    (cfg_xor),
    .cfg_commit_i (cfg_commit),
    .cfg_req_i    (cfg_req),
    .cfg_busy_o   (cfg_busy),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_code_i    (in_code),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: matrix, semiring, mode (0 cfg, 1 run, 2 drain), pending output.
  logic [M-1:0] mb [K];
  logic         mxor;
  int           mstate;
  logic [M-1:0] pend [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [M-1:0] ref_reduce(input logic [K-1:0] code);
    logic [M-1:0] acc;
    acc = '0;
    for (int k = 0; k < int'(K); k++) begin
      if (code[k]) acc = mxor ? (acc ^ mb[k]) : (acc | mb[k]);
    end
    return acc;
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int k = 0; k < int'(K); k++) mb[k] = '0;
    mxor   = 1'b0;
    mstate = 0;
  endtask

  // Check the current cycle against the model, advance the model, then take one clock edge.
  task automatic cycle();
    logic was_empty, fin, fout, exp_ready;
    #1;
    if (rst_n) begin
      was_empty = (pend.size() == 0);
      exp_ready = (mstate == 1) && (was_empty || out_ready);
      check_eq("out_valid", 32'(out_valid), 32'(!was_empty));
      if (!was_empty) check_eq("out_data", 32'(out_data), 32'(pend[0]));
      check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
      check_eq("cfg_busy", 32'(cfg_busy), 32'(mstate != 1));
      fout = !was_empty && out_ready;
      fin  = exp_ready && in_valid;
      if (fout) void'(pend.pop_front());
      if (fin) pend.push_back(ref_reduce(in_code));
      case (mstate)
        0: begin
          if (cfg_we && cfg_row < RowW'(K)) mb[cfg_row] = cfg_data;
          if (cfg_commit) begin
            mxor   = cfg_xor;
            mstate = 1;
          end
        end
        1: if (cfg_req) mstate = 2;
        default: if (was_empty) mstate = 0;
      endcase
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_row(input logic [RowW-1:0] r, input logic [M-1:0] d);
    cfg_we = 1'b1; cfg_row = r; cfg_data = d;
    cycle();
    cfg_we = 1'b0;
  endtask

  task automatic commit(input logic x);
    cfg_commit = 1'b1; cfg_xor = x;
    cycle();
    cfg_commit = 1'b0;
    check_eq("commit_busy", 32'(cfg_busy), 32'd0);
  endtask

  task automatic send(input logic [K-1:0] c, input logic [M-1:0] exp, input string tag);
    in_valid = 1'b1; in_code = c;
    cycle();
    in_valid = 1'b0;
    check_eq(tag, 32'(out_data), 32'(exp));
  endtask

  task automatic reconfig();
    cfg_req = 1'b1;
    cycle();
    cfg_req = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_row = '0; cfg_data = '0; cfg_xor = 1'b0;
    cfg_commit = 1'b0; cfg_req = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    check_eq("rst_busy", 32'(cfg_busy), 32'd1);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd0);

    // OR semiring
    load_row(2'd0, 4'b0011);
    load_row(2'd1, 4'b0110);
    load_row(2'd2, 4'b1000);
    commit(1'b0);
    out_ready = 1'b1;
    send(3'b011, 4'b0111, "or_011");

    // Stall with a code waiting, then release in the same cycle it is taken
    out_ready = 1'b0;
    in_valid = 1'b1; in_code = 3'b001;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("stall_ready", 32'(in_ready), 32'd0);
      check_eq("stall_hold", 32'(out_data), 32'h7);
    end
    out_ready = 1'b1;
    #1;
    check_eq("release_ready", 32'(in_ready), 32'd1);
    send(3'b001, 4'b0011, "release_take");

    // Back-to-back, no bubbles
    send(3'b001, 4'b0011, "b2b_001");
    send(3'b010, 4'b0110, "b2b_010");
    send(3'b100, 4'b1000, "b2b_100");

    // XOR semiring on the same matrix
    reconfig();
    check_eq("reconf_busy", 32'(cfg_busy), 32'd1);
    commit(1'b1);
    send(3'b011, 4'b0101, "xor_011");
    send(3'b111, 4'b1101, "xor_111");
    send(3'b000, 4'b0000, "xor_000");

    // Reconfigure while an output is held
    send(3'b111, 4'b1101, "pend_111");
    out_ready = 1'b0;
    cfg_req = 1'b1;
    cycle();
    cfg_req = 1'b0;
    check_eq("drain_ready", 32'(in_ready), 32'd0);
    check_eq("drain_busy", 32'(cfg_busy), 32'd1);
    check_eq("drain_hold", 32'(out_valid), 32'd1);
    cycle();
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    load_row(2'd0, 4'b1111);
    commit(1'b1);
    send(3'b001, 4'b1111, "rewrite_b0");

    // Reset with an output pending
    out_ready = 1'b0;
    send(3'b001, 4'b1111, "pre_rst");
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check_eq("midrst_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_data", 32'(out_data), 32'd0);
    check_eq("midrst_busy", 32'(cfg_busy), 32'd1);
    commit(1'b0);
    out_ready = 1'b1;
    send(3'b111, 4'b0000, "cleared");

    // Randomized traffic with reconfigurations and out-of-state controls
    for (int i = 0; i < 1500; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_code    = K'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      cfg_we     = ($urandom_range(0, 2) == 0);
      cfg_row    = RowW'($urandom);
      cfg_data   = M'($urandom);
      cfg_xor    = 1'($urandom);
      cfg_commit = ($urandom_range(0, 7) == 0);
      cfg_req    = ($urandom_range(0, 40) == 0);
      rst_n      = ($urandom_range(0, 300) != 0);
      cycle();
    end
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
